// File: rtl/spi_flash_responder.sv
// ============================================================================
// spi_flash_responder
//
// Purpose: SPI mode-0 target that looks like a small serial flash to an
// external initiator. Supports READ (0x03) with an unbounded incrementing
// byte stream, RELEASE/WAKE (0xAB, accepted and ignored) and, optionally,
// READ JEDEC ID (0x9F). All SPI pins are asynchronous to clk and are
// oversampled through a synchronizer chain. SCK must be at most clk/8.
//
// Build option: define SPI_FLASH_JEDEC_EN to enable opcode 0x9F. Without it
// 0x9F is treated like any other unsupported opcode.
//
// Parameters:
//   SYNC_STAGES  synchronizer depth for spi_sck/spi_cs_n/spi_mosi (>= 2)
//   JEDEC_ID     3 ID bytes returned MSB-first by 0x9F
//
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   spi_sck           SPI clock (mode 0, idles low)
//   spi_cs_n          chip select, active low
//   spi_mosi          serial data in, MSB first
//   spi_miso          serial data out, MSB first, changes on SCK fall
//   mem_rd, mem_addr  one-clk byte read strobe and its byte address
//   mem_rdata         read byte, valid exactly one clk after mem_rd
//   cmd_valid         one-clk pulse when an opcode byte completes
//   cmd_opcode        last completed opcode
//   err_unsupported   sticky unsupported-opcode flag
// ============================================================================
module spi_flash_responder #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [23:0] JEDEC_ID    = 24'hEF4016
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        spi_sck,
    input  logic        spi_cs_n,
    input  logic        spi_mosi,
    output logic        spi_miso,
    output logic        mem_rd,
    output logic [23:0] mem_addr,
    input  logic [7:0]  mem_rdata,
    output logic        cmd_valid,
    output logic [7:0]  cmd_opcode,
    output logic        err_unsupported
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_DATA,
        S_IGNORE
`ifdef SPI_FLASH_JEDEC_EN
        , S_ID
`endif
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic                   sck_prev_q, sck_prev_d;
    logic                   cs_prev_q, cs_prev_d;
    logic [4:0]             bit_cnt_q, bit_cnt_d;
    logic [22:0]            shift_q, shift_d;
    logic [7:0]             tx_q, tx_d;
    logic                   miso_q, miso_d;
    logic                   mem_rd_q, mem_rd_d;
    logic                   rd_dly_q, rd_dly_d;
    logic [23:0]            mem_addr_q, mem_addr_d;
    logic                   cmd_valid_q, cmd_valid_d;
    logic [7:0]             cmd_opcode_q, cmd_opcode_d;
    logic                   err_q, err_d;
`ifdef SPI_FLASH_JEDEC_EN
    logic [1:0]             id_idx_q, id_idx_d;
    logic [7:0]             id_byte;
`else
    // JEDEC_ID stays on the parameter list so both builds share one interface.
    localparam logic [23:0] JEDEC_ID_UNUSED = JEDEC_ID;
`endif

    logic       sck_s, cs_s, mosi_s;
    logic       sck_rise, sck_fall, cs_fall;
    logic [7:0] opcode_now;
    logic [23:0] addr_now;

    assign sck_s  = sck_sync_q[SYNC_STAGES-1];
    assign cs_s   = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    // Edges are found against one extra registered copy of the synchronized level.
    assign sck_rise = sck_s & ~sck_prev_q;
    assign sck_fall = ~sck_s & sck_prev_q;
    assign cs_fall  = ~cs_s & cs_prev_q;

    // Values as they will be once the bit arriving on this rise is shifted in.
    assign opcode_now = {shift_q[6:0], mosi_s};
    assign addr_now   = {shift_q, mosi_s};

`ifdef SPI_FLASH_JEDEC_EN
    always_comb begin
        case (id_idx_q)
            2'd0:    id_byte = JEDEC_ID[23:16];
            2'd1:    id_byte = JEDEC_ID[15:8];
            default: id_byte = JEDEC_ID[7:0];
        endcase
    end
`endif

    always_comb begin
        state_d      = state_q;
        sck_sync_d   = {sck_sync_q[SYNC_STAGES-2:0], spi_sck};
        cs_sync_d    = {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
        mosi_sync_d  = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
        sck_prev_d   = sck_s;
        cs_prev_d    = cs_s;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        tx_d         = tx_q;
        miso_d       = miso_q;
        mem_rd_d     = 1'b0;
        rd_dly_d     = mem_rd_q;
        mem_addr_d   = mem_addr_q;
        cmd_valid_d  = 1'b0;
        cmd_opcode_d = cmd_opcode_q;
        err_d        = err_q;
`ifdef SPI_FLASH_JEDEC_EN
        id_idx_d     = id_idx_q;
`endif

        if (state_q != S_IDLE && cs_s) begin
            // Deselect wins over any SCK edge seen in the same clk.
            state_d   = S_IDLE;
            bit_cnt_d = '0;
            tx_d      = '0;
            miso_d    = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cs_fall) begin
                        state_d   = S_CMD;
                        bit_cnt_d = '0;
                        miso_d    = 1'b0;
                    end
                end
                S_CMD: begin
                    if (sck_rise) begin
                        shift_d   = {shift_q[21:0], mosi_s};
                        bit_cnt_d = bit_cnt_q + 5'd1;
                        if (bit_cnt_q == 5'd7) begin
                            bit_cnt_d    = '0;
                            cmd_valid_d  = 1'b1;
                            cmd_opcode_d = opcode_now;
                            case (opcode_now)
                                8'h03: state_d = S_ADDR;
                                8'hAB: state_d = S_IGNORE;
`ifdef SPI_FLASH_JEDEC_EN
                                8'h9F: begin
                                    state_d  = S_ID;
                                    tx_d     = JEDEC_ID[23:16];
                                    id_idx_d = 2'd1;
                                end
`endif
                                default: begin
                                    state_d = S_IGNORE;
                                    err_d   = 1'b1;
                                end
                            endcase
                        end
                    end
                end
                S_ADDR: begin
                    if (sck_rise) begin
                        shift_d   = {shift_q[21:0], mosi_s};
                        bit_cnt_d = bit_cnt_q + 5'd1;
                        if (bit_cnt_q == 5'd23) begin
                            bit_cnt_d  = '0;
                            mem_rd_d   = 1'b1;
                            mem_addr_d = addr_now;
                            state_d    = S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (sck_rise) begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                        if (bit_cnt_q == 5'd7) begin
                            // Prefetch the next byte as the current one completes.
                            bit_cnt_d  = '0;
                            mem_addr_d = mem_addr_q + 24'd1;
                            mem_rd_d   = 1'b1;
                        end
                    end
                    if (sck_fall) begin
                        miso_d = tx_q[7];
                        tx_d   = {tx_q[6:0], 1'b0};
                    end
                    // mem_rdata is valid the clk after mem_rd; SCK is slow
                    // enough that this always lands before the next fall.
                    if (rd_dly_q) begin
                        tx_d = mem_rdata;
                    end
                end
`ifdef SPI_FLASH_JEDEC_EN
                S_ID: begin
                    if (sck_rise) begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                        if (bit_cnt_q == 5'd7) begin
                            bit_cnt_d = '0;
                            tx_d      = id_byte;
                            id_idx_d  = (id_idx_q == 2'd2) ? 2'd0 : id_idx_q + 2'd1;
                        end
                    end
                    if (sck_fall) begin
                        miso_d = tx_q[7];
                        tx_d   = {tx_q[6:0], 1'b0};
                    end
                end
`endif
                S_IGNORE: begin
                    miso_d = 1'b0;
                end
                default: begin
                    state_d = S_IDLE;
                    miso_d  = 1'b0;
                end
            endcase
        end
    end

    // Sync chains reset low so a cs_n already held low after reset never
    // looks like a falling edge; only a fresh high-then-low starts a frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            sck_sync_q   <= '0;
            cs_sync_q    <= '0;
            mosi_sync_q  <= '0;
            sck_prev_q   <= 1'b0;
            cs_prev_q    <= 1'b0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            tx_q         <= '0;
            miso_q       <= 1'b0;
            mem_rd_q     <= 1'b0;
            rd_dly_q     <= 1'b0;
            mem_addr_q   <= '0;
            cmd_valid_q  <= 1'b0;
            cmd_opcode_q <= 8'h00;
            err_q        <= 1'b0;
`ifdef SPI_FLASH_JEDEC_EN
            id_idx_q     <= '0;
`endif
        end else begin
            state_q      <= state_d;
            sck_sync_q   <= sck_sync_d;
            cs_sync_q    <= cs_sync_d;
            mosi_sync_q  <= mosi_sync_d;
            sck_prev_q   <= sck_prev_d;
            cs_prev_q    <= cs_prev_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            tx_q         <= tx_d;
            miso_q       <= miso_d;
            mem_rd_q     <= mem_rd_d;
            rd_dly_q     <= rd_dly_d;
            mem_addr_q   <= mem_addr_d;
            cmd_valid_q  <= cmd_valid_d;
            cmd_opcode_q <= cmd_opcode_d;
            err_q        <= err_d;
`ifdef SPI_FLASH_JEDEC_EN
            id_idx_q     <= id_idx_d;
`endif
        end
    end

    assign spi_miso        = miso_q;
    assign mem_rd          = mem_rd_q;
    assign mem_addr        = mem_addr_q;
    assign cmd_valid       = cmd_valid_q;
    assign cmd_opcode      = cmd_opcode_q;
    assign err_unsupported = err_q;

endmodule

// File: tb/tb_spi_flash_responder.sv
// ============================================================================
// tb_spi_flash_responder
//
// Drives whole SPI frames from an initiator-side model and compares MISO
// bytes, memory read addresses, cmd_valid/cmd_opcode and err_unsupported
// against expectations derived from the flash command rules.
// ============================================================================
module tb_spi_flash_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        spi_sck;
    logic        spi_cs_n;
    logic        spi_mosi;
    logic        spi_miso;
    logic        mem_rd;
    logic [23:0] mem_addr;
    logic [7:0]  mem_rdata = 8'h00;
    logic        cmd_valid;
    logic [7:0]  cmd_opcode;
    logic        err_unsupported;

`ifdef SPI_FLASH_JEDEC_EN
    localparam bit JEDEC_ON = 1'b1;
`else
    localparam bit JEDEC_ON = 1'b0;
`endif
    localparam logic [23:0] JEDEC = 24'hEF4016;

    int checks = 0;
    int errors = 0;
    int cv_count = 0;
    logic err_model = 1'b0;
    logic [7:0]  mem_bytes [256];
    logic [23:0] rd_log [$];
    logic [7:0]  rx_q [$];

    typedef struct {
        logic [7:0]  op;
        logic [23:0] addr;
        int          nbytes;
        logic        exp_err;
    } vec_t;
    vec_t vecs [5];

    spi_flash_responder #(.SYNC_STAGES(2), .JEDEC_ID(JEDEC)) dut (
        .clk             (clk),
        .reset           (reset),
        .spi_sck         (spi_sck),
        .spi_cs_n        (spi_cs_n),
        .spi_mosi        (spi_mosi),
        .spi_miso        (spi_miso),
        .mem_rd          (mem_rd),
        .mem_addr        (mem_addr),
        .mem_rdata       (mem_rdata),
        .cmd_valid       (cmd_valid),
        .cmd_opcode      (cmd_opcode),
        .err_unsupported (err_unsupported)
    );

    always #5 clk = ~clk;

    // Backing memory: content is a function of the full 24-bit address.
    function automatic logic [7:0] memAt(input logic [23:0] a);
        return mem_bytes[a[7:0]] ^ a[23:16];
    endfunction

    // Memory answers one clk after each read strobe; strobes are logged.
    always @(posedge clk) begin
        if (mem_rd) begin
            mem_rdata <= memAt(mem_addr);
            rd_log.push_back(mem_addr);
        end
        if (cmd_valid) cv_count <= cv_count + 1;
    end

    // Expected MISO byte i of the data phase for a given command.
    function automatic logic [7:0] modelByte(input logic [7:0] op, input logic [23:0] addr, input int i);
        logic [23:0] a;
        a = addr + 24'(i);
        if (op == 8'h03) return memAt(a);
        if (op == 8'h9F && JEDEC_ON) begin
            case (i % 3)
                0:       return JEDEC[23:16];
                1:       return JEDEC[15:8];
                default: return JEDEC[7:0];
            endcase
        end
        return 8'h00;
    endfunction

    function automatic logic modelUnsupported(input logic [7:0] op);
        return !(op == 8'h03 || op == 8'hAB || (op == 8'h9F && JEDEC_ON));
    endfunction

    task automatic waitClk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // One SPI bit, mode 0: MOSI set while SCK low, MISO sampled at the rise.
    task automatic spiBit(input logic b, output logic r);
        spi_mosi = b;
        waitClk(5);
        r = spi_miso;
        spi_sck = 1'b1;
        waitClk(5);
        spi_sck = 1'b0;
    endtask

    task automatic spiByte(input logic [7:0] tx, output logic [7:0] rx);
        logic r;
        rx = 8'h00;
        for (int i = 7; i >= 0; i--) begin
            spiBit(tx[i], r);
            rx = {rx[6:0], r};
        end
    endtask

    // Full frame: select, opcode, address for READ, nbytes of data, deselect.
    task automatic applyStimulus(input logic [7:0] op, input logic [23:0] addr, input int nbytes);
        logic [7:0] r;
        rx_q.delete();
        rd_log.delete();
        spi_cs_n = 1'b0;
        waitClk(6);
        spiByte(op, r);
        if (op == 8'h03) begin
            spiByte(addr[23:16], r);
            spiByte(addr[15:8], r);
            spiByte(addr[7:0], r);
        end
        for (int i = 0; i < nbytes; i++) begin
            spiByte(8'h00, r);
            rx_q.push_back(r);
        end
        waitClk(6);
        spi_cs_n = 1'b1;
        waitClk(8);
    endtask

    task automatic verifyFrame(input string tag, input logic [7:0] op, input logic [23:0] addr,
                               input int nbytes, input logic exp_err, input int cv_before);
        int exp_reads;
        checkOutput({tag, " cmd_valid pulses"}, 32'(cv_count - cv_before), 32'd1);
        checkOutput({tag, " cmd_opcode"}, {24'h0, cmd_opcode}, {24'h0, op});
        checkOutput({tag, " err_unsupported"}, {31'h0, err_unsupported}, {31'h0, exp_err});
        for (int i = 0; i < nbytes; i++) begin
            checkOutput($sformatf("%s miso byte %0d", tag, i),
                        (i < rx_q.size()) ? {24'h0, rx_q[i]} : 32'hFFFF_FFFF,
                        {24'h0, modelByte(op, addr, i)});
        end
        // A READ prefetches one byte beyond the last one clocked out.
        exp_reads = (op == 8'h03) ? nbytes + 1 : 0;
        checkOutput({tag, " mem_rd count"}, 32'(rd_log.size()), 32'(exp_reads));
        for (int k = 0; k < exp_reads && k < rd_log.size(); k++) begin
            checkOutput($sformatf("%s mem_addr %0d", tag, k), {8'h0, rd_log[k]}, {8'h0, addr + 24'(k)});
        end
        checkOutput({tag, " miso idle"}, {31'h0, spi_miso}, 32'h0);
    endtask

    task automatic runFrame(input string tag, input logic [7:0] op, input logic [23:0] addr, input int nbytes);
        int cv_before;
        cv_before = cv_count;
        applyStimulus(op, addr, nbytes);
        err_model = err_model | modelUnsupported(op);
        verifyFrame(tag, op, addr, nbytes, err_model, cv_before);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, " spi_miso"}, {31'h0, spi_miso}, 32'h0);
        checkOutput({tag, " mem_rd"}, {31'h0, mem_rd}, 32'h0);
        checkOutput({tag, " mem_addr"}, {8'h0, mem_addr}, 32'h0);
        checkOutput({tag, " cmd_valid"}, {31'h0, cmd_valid}, 32'h0);
        checkOutput({tag, " cmd_opcode"}, {24'h0, cmd_opcode}, 32'h0);
        checkOutput({tag, " err_unsupported"}, {31'h0, err_unsupported}, 32'h0);
    endtask

    // Watchdog so the run always ends even if the bench itself stalls.
    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int cv_before;
        logic [7:0] r;
        logic rb;
        logic [7:0] op;
        logic [23:0] addr;
        int nb;

        for (int i = 0; i < 256; i++) mem_bytes[i] = 8'($urandom);
        mem_bytes[8'h10] = 8'hA5;
        mem_bytes[8'h11] = 8'h3C;

        vecs[0] = '{op: 8'h03, addr: 24'h000010, nbytes: 2, exp_err: 1'b0};
        vecs[1] = '{op: 8'h03, addr: 24'hFFFFFF, nbytes: 2, exp_err: 1'b0};
        vecs[2] = '{op: 8'hAB, addr: 24'h000000, nbytes: 1, exp_err: 1'b0};
        vecs[3] = '{op: 8'h55, addr: 24'h000000, nbytes: 2, exp_err: 1'b1};
        vecs[4] = '{op: 8'h9F, addr: 24'h000000, nbytes: 4, exp_err: 1'b1};

        spi_sck  = 1'b0;
        spi_cs_n = 1'b1;
        spi_mosi = 1'b0;
        reset    = 1'b1;
        waitClk(4);
        reset = 1'b0;
        waitClk(4);
        checkResetOutputs("reset");

        // SCK activity with chip deselected must be invisible.
        rd_log.delete();
        cv_before = cv_count;
        for (int i = 0; i < 8; i++) spiBit(1'b1, rb);
        waitClk(6);
        checkOutput("deselected cmd_valid", 32'(cv_count - cv_before), 32'd0);
        checkOutput("deselected mem_rd", 32'(rd_log.size()), 32'd0);

        // Directed command table.
        for (int v = 0; v < 5; v++) begin
            cv_before = cv_count;
            applyStimulus(vecs[v].op, vecs[v].addr, vecs[v].nbytes);
            err_model = err_model | modelUnsupported(vecs[v].op);
            verifyFrame($sformatf("vec%0d", v), vecs[v].op, vecs[v].addr, vecs[v].nbytes,
                        vecs[v].exp_err, cv_before);
        end

        // Abort after 12 address bits: no read, then a clean READ works.
        rd_log.delete();
        cv_before = cv_count;
        spi_cs_n = 1'b0;
        waitClk(6);
        spiByte(8'h03, r);
        for (int i = 0; i < 12; i++) spiBit(1'b1, rb);
        waitClk(4);
        spi_cs_n = 1'b1;
        waitClk(8);
        checkOutput("abort mem_rd", 32'(rd_log.size()), 32'd0);
        checkOutput("abort cmd_valid", 32'(cv_count - cv_before), 32'd1);
        checkOutput("abort miso", {31'h0, spi_miso}, 32'h0);
        runFrame("after abort", 8'h03, 24'h000020, 2);

        // Randomized frames, biased toward the address wrap.
        for (int n = 0; n < 8; n++) begin
            op   = ($urandom_range(0, 3) == 0) ? 8'hAB : 8'h03;
            addr = 24'($urandom);
            if ($urandom_range(0, 3) == 0) addr = 24'hFFFFFE;
            nb   = $urandom_range(1, 3);
            runFrame($sformatf("rand%0d", n), op, addr, nb);
        end

        // Reset in the middle of DATA with cs_n held low.
        spi_cs_n = 1'b0;
        waitClk(6);
        spiByte(8'h03, r);
        spiByte(8'h00, r);
        spiByte(8'h00, r);
        spiByte(8'h40, r);
        spiByte(8'h00, r);
        reset = 1'b1;
        waitClk(2);
        reset = 1'b0;
        err_model = 1'b0;
        waitClk(2);
        checkResetOutputs("mid-data reset");
        rd_log.delete();
        cv_before = cv_count;
        for (int i = 0; i < 16; i++) spiBit((i % 8) >= 6, rb);
        waitClk(6);
        checkOutput("post-reset mem_rd", 32'(rd_log.size()), 32'd0);
        checkOutput("post-reset cmd_valid", 32'(cv_count - cv_before), 32'd0);
        checkOutput("post-reset miso", {31'h0, spi_miso}, 32'h0);
        spi_cs_n = 1'b1;
        waitClk(8);
        runFrame("fresh frame", 8'h03, 24'h000011, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_flash_responder.md
SPI_FLASH_RESPONDER -- requirements
Module: spi_flash_responder

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, input synchronizer depth for spi_sck/spi_cs_n/spi_mosi (minimum 2).
REQ-002 SHALL have parameter JEDEC_ID, default 24'hEF4016, ID bytes returned MSB-first by opcode 0x9F.
REQ-003 SHALL have one clock and a synchronous, active-high reset.
REQ-004 clk  input  1  system clock; all state on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 spi_sck  input  1  SPI clock from flash initiator, asynchronous, mode 0.
REQ-007 spi_cs_n  input  1  chip select, active low, asynchronous.
REQ-008 spi_mosi  input  1  serial data from initiator, MSB first.
REQ-009 spi_miso  output  1  serial data to initiator, MSB first.
REQ-010 mem_rd  output  1  one-clk byte read strobe.
REQ-011 mem_addr  output  24  byte address, valid while mem_rd=1.
REQ-012 mem_rdata  input  8  read byte, valid exactly 1 clk after mem_rd.
REQ-013 cmd_valid  output  1  one-clk pulse when an opcode byte completes.
REQ-014 cmd_opcode  output  8  last completed opcode, held until next.
REQ-015 err_unsupported  output  1  sticky flag, set on unsupported opcode, cleared only by reset.

Function
REQ-016 SHALL pass each SPI input through SYNC_STAGES flops, then detect SCK rise/fall by comparing with one further registered copy.
REQ-017 SHALL sample spi_mosi on synchronized SCK rise and update spi_miso only on synchronized SCK fall (mode 0); spi_sck max frequency is clk/8.
REQ-018 SHALL implement states IDLE, CMD, ADDR, DATA, ID, IGNORE.
REQ-019 IDLE->CMD on synchronized cs_n falling; bit counter cleared, spi_miso=0.
REQ-020 CMD: after 8th rise, pulse cmd_valid, latch cmd_opcode; 0x03->ADDR, 0x9F->ID (when enabled), 0xAB->IGNORE without error, any other->IGNORE and set err_unsupported.
REQ-021 ADDR: shift 24 bits MSB first; on 24th rise, assert mem_rd for 1 clk with mem_addr = shifted address, enter DATA.
REQ-022 DATA: load mem_rdata into tx shift register the clk after mem_rd; drive bit 7 at the next SCK fall, bits 6..0 on following falls.
REQ-023 DATA: on rise of each byte's 8th bit, increment address (modulo 2^24, 24'hFFFFFF->24'h000000) and issue next mem_rd; stream unbounded until cs_n high.
REQ-024 ID: drive JEDEC_ID[23:16], [15:8], [7:0] on successive bytes, then repeat from [23:16].
REQ-025 IGNORE: spi_miso=0, all further bits discarded until cs_n high.
REQ-026 Synchronized cs_n high in any state SHALL return to IDLE the next clk, drop spi_miso to 0, abort without issuing further mem_rd; a mid-byte partial opcode does not pulse cmd_valid.
REQ-027 SCK edges while cs_n high SHALL be ignored.
REQ-028 Simultaneous cs_n rise and SCK edge in one clk: cs_n wins; edge discarded.

Reset
REQ-029 Reset SHALL force IDLE, clear counters/shift registers/address, and drive spi_miso=0, mem_rd=0, mem_addr=0, cmd_valid=0, cmd_opcode=8'h00, err_unsupported=0.
REQ-030 Reset asserted mid-transaction SHALL abort it; after release the block waits for a fresh cs_n falling edge (cs_n already low is not a start).

Configuration
REQ-031 Macro SPI_FLASH_JEDEC_EN defined: opcode 0x9F handled per REQ-020/REQ-024.
REQ-032 SPI_FLASH_JEDEC_EN undefined: ID state and JEDEC_ID logic absent; 0x9F treated as unsupported (IGNORE, err_unsupported=1).

Verification
REQ-033 Read: cs_n low, send 0x03 + 24'h000010, clock 16 data bits, mem returns 0xA5,0x3C -> mem_rd addrs 0x000010,0x000011; MISO bytes 0xA5,0x3C; cmd_opcode=0x03.
REQ-034 Wrap: 0x03 + 24'hFFFFFF, read 2 bytes -> mem_addr 0xFFFFFF then 0x000000.
REQ-035 JEDEC (macro on): send 0x9F, read 4 bytes -> 0xEF,0x40,0x16,0xEF; macro off -> MISO 0x00 all bytes, err_unsupported=1.
REQ-036 Wake+unsupported: send 0xAB -> cmd_valid 1 pulse, err_unsupported=0; new frame 0x55 -> err_unsupported=1, MISO 0.
REQ-037 Abort: raise cs_n after 12 address bits -> no mem_rd, state IDLE; next 0x03 frame to 24'h000020 reads correctly.
REQ-038 Reset mid-DATA with cs_n held low -> all outputs reset values; SCK pulses produce no mem_rd until cs_n toggles high then low.
